// File: rtl/shadow_bank_pkg.sv
// Shared types for the shadow register-bank stack: FSM state encoding and
// the frame layout (NUM_REGS words of DATA_WIDTH bits, word 0 in the LSBs).
package shadow_bank_pkg;

    // Default frame geometry of the stack.
    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_NUM_REGS   = 32;

    // Controller states: idle, writing the bottom frame out, and the
    // two-phase read of a spilled frame back into a slot.
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SPILL     = 2'd1,
        S_FILL_REQ  = 2'd2,
        S_FILL_WAIT = 2'd3
    } state_e;

    // One saved frame at the default geometry. The stack declares the same
    // layout from its own parameters so that other geometries still work.
    typedef logic [DEF_NUM_REGS-1:0][DEF_DATA_WIDTH-1:0] frame_t;

endpackage

// File: rtl/shadow_bank_mem_port.sv
// Word sequencer for frame spills and fills: walks word indices 0..NUM_REGS-1,
// drives the req/gnt request phase for both directions, and reports each
// completed word back to the stack controller.
module shadow_bank_mem_port
    import shadow_bank_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REGS   = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  state_e                      state_i,
    input  logic                        start_i,
    input  logic [DATA_WIDTH-1:0]       frame_base_i,
    input  logic [DATA_WIDTH-1:0]       spill_word_i,
    input  logic                        mem_gnt_i,
    input  logic                        mem_rvalid_i,
    output logic                        mem_req_o,
    output logic                        mem_we_o,
    output logic [DATA_WIDTH-1:0]       mem_addr_o,
    output logic [DATA_WIDTH-1:0]       mem_wdata_o,
    output logic [$clog2(NUM_REGS)-1:0] word_idx_o,
    output logic                        word_last_o,
    output logic                        spill_step_o,
    output logic                        fill_granted_o,
    output logic                        fill_step_o
);

    localparam int                    IDX_W      = $clog2(NUM_REGS);
    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_REGS - 1);
    localparam logic [DATA_WIDTH-1:0] WORD_BYTES = DATA_WIDTH'(DATA_WIDTH / 8);

    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] r_base;
    logic                  w_req;
    logic                  w_we;

    // A request is open for every SPILL cycle and every FILL_REQ cycle; only
    // one read is ever outstanding because FILL_WAIT drops the request.
    assign w_we           = (state_i == S_SPILL);
    assign w_req          = w_we || (state_i == S_FILL_REQ);
    assign spill_step_o   = w_we && mem_gnt_i;
    assign fill_granted_o = (state_i == S_FILL_REQ) && mem_gnt_i;
    assign fill_step_o    = (state_i == S_FILL_WAIT) && mem_rvalid_i;
    assign word_last_o    = (r_idx == LAST_IDX);
    assign word_idx_o     = r_idx;

    // Latch the frame base at transfer start and step the word index per word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: registers are updated with <= so every flop samples the
        // pre-edge values of the others, independent of statement order.
        if (rst_i) begin
            r_idx  <= '0;
            r_base <= '0;
        end else if (start_i) begin
            r_idx  <= '0;
            r_base <= frame_base_i;
        end else if (spill_step_o || fill_step_o) begin
            r_idx <= word_last_o ? '0 : r_idx + IDX_W'(1);
        end
    end

    // Address and data are held stable until the grant; idle port reads as 0.
    assign mem_req_o   = w_req;
    assign mem_we_o    = w_we;
    assign mem_addr_o  = w_req ? (r_base + DATA_WIDTH'(r_idx) * WORD_BYTES) : '0;
    assign mem_wdata_o = w_we ? spill_word_i : '0;

endmodule

// File: rtl/shadow_bank_stack.sv
// Shadow register-bank stack: NUM_BANKS on-chip frame slots used as a
// circular window over a deeper stack of MAX_DEPTH frames. The bottom
// resident frame is spilled to memory when a save finds the window full, and
// the most recently spilled frame is filled back when a restore finds it empty.
module shadow_bank_stack
    import shadow_bank_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REGS   = 32,
    parameter int NUM_BANKS  = 4,
    parameter int MAX_DEPTH  = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             save_valid_i,
    output logic                             save_ready_o,
    input  logic [NUM_REGS*DATA_WIDTH-1:0]   save_data_i,
    input  logic                             restore_valid_i,
    output logic                             restore_ready_o,
    output logic [NUM_REGS*DATA_WIDTH-1:0]   restore_data_o,
    input  logic [$clog2(NUM_REGS)-1:0]      rd_addr_i,
    output logic [DATA_WIDTH-1:0]            rd_data_o,
    input  logic [DATA_WIDTH-1:0]            stack_base_i,
    output logic                             mem_req_o,
    output logic                             mem_we_o,
    output logic [DATA_WIDTH-1:0]            mem_addr_o,
    output logic [DATA_WIDTH-1:0]            mem_wdata_o,
    input  logic                             mem_gnt_i,
    input  logic                             mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]            mem_rdata_i,
    output logic [$clog2(MAX_DEPTH+1)-1:0]   depth_o,
    output logic [$clog2(NUM_BANKS+1)-1:0]   onchip_o,
    output logic                             busy_o,
    output logic                             err_o
);

    localparam int IDX_W   = $clog2(NUM_REGS);
    localparam int BANK_W  = $clog2(NUM_BANKS);
    localparam int OC_W    = $clog2(NUM_BANKS + 1);
    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

    localparam logic [OC_W-1:0]       OC_FULL     = OC_W'(NUM_BANKS);
    localparam logic [DEPTH_W-1:0]    DEPTH_MAX   = DEPTH_W'(MAX_DEPTH);
    localparam logic [DATA_WIDTH-1:0] FRAME_BYTES = DATA_WIDTH'(NUM_REGS * (DATA_WIDTH / 8));

    // Same layout as shadow_bank_pkg::frame_t, sized by this instance.
    typedef logic [NUM_REGS-1:0][DATA_WIDTH-1:0] slot_t;

    state_e             r_state;
    state_e             w_state_next;
    slot_t              r_slots [NUM_BANKS];
    logic [BANK_W-1:0]  r_bot;
    logic [OC_W-1:0]    r_oc;
    logic [DEPTH_W-1:0] r_sp;
    logic               r_err;

    logic [DEPTH_W-1:0]    w_depth;
    logic [BANK_W-1:0]     w_top_slot;
    logic [BANK_W-1:0]     w_push_slot;
    logic [BANK_W-1:0]     w_fill_slot;
    logic                  w_save_ok;
    logic                  w_restore_ok;
    logic                  w_save_fire;
    logic                  w_restore_fire;
    logic                  w_start_spill;
    logic                  w_start_fill;
    logic                  w_err;
    logic [DEPTH_W-1:0]    w_frame_idx;
    logic [DATA_WIDTH-1:0] w_frame_base;
    logic [IDX_W-1:0]      w_word_idx;
    logic                  w_word_last;
    logic                  w_spill_step;
    logic                  w_fill_granted;
    logic                  w_fill_step;
    logic                  w_spill_done;
    logic                  w_fill_done;

    // Slot arithmetic is modulo NUM_BANKS through truncation to BANK_W bits.
    assign w_depth     = DEPTH_W'(r_oc) + r_sp;
    assign w_top_slot  = r_bot + r_oc[BANK_W-1:0] - BANK_W'(1);
    assign w_push_slot = r_bot + r_oc[BANK_W-1:0];
    assign w_fill_slot = r_bot - BANK_W'(1);

    // Handshakes. Restore wins a same-cycle tie because a pending restore
    // forces the save ready low.
    assign w_restore_ok   = (r_state == S_IDLE) && (r_oc != '0);
    assign w_save_ok      = (r_state == S_IDLE) && (r_oc < OC_FULL) &&
                            (w_depth < DEPTH_MAX) && !restore_valid_i;
    assign w_restore_fire = restore_valid_i && w_restore_ok;
    assign w_save_fire    = save_valid_i && w_save_ok;
    assign w_spill_done   = w_spill_step && w_word_last;
    assign w_fill_done    = w_fill_step && w_word_last;

    // A spill writes frame number sp; a fill reads back frame number sp-1.
    assign w_frame_idx  = w_start_fill ? (r_sp - DEPTH_W'(1)) : r_sp;
    assign w_frame_base = stack_base_i + DATA_WIDTH'(w_frame_idx) * FRAME_BYTES;

    // Next-state decode plus the spill/fill start and error strobes.
    always_comb begin
        // NOTE: defaults come first so that every path assigns every signal
        // and no latch is inferred.
        w_state_next  = r_state;
        w_start_spill = 1'b0;
        w_start_fill  = 1'b0;
        w_err         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (restore_valid_i) begin
                    if (r_oc == '0 && r_sp != '0) begin
                        w_start_fill = 1'b1;
                        w_state_next = S_FILL_REQ;
                    end else if (w_depth == '0) begin
                        w_err = 1'b1;
                    end
                end else if (save_valid_i) begin
                    if (w_depth == DEPTH_MAX) begin
                        w_err = 1'b1;
                    end else if (r_oc == OC_FULL) begin
                        w_start_spill = 1'b1;
                        w_state_next  = S_SPILL;
                    end
                end
            end
            S_SPILL: begin
                if (w_spill_done) w_state_next = S_IDLE;
            end
            S_FILL_REQ: begin
                if (w_fill_granted) w_state_next = S_FILL_WAIT;
            end
            S_FILL_WAIT: begin
                if (w_fill_step) w_state_next = w_word_last ? S_IDLE : S_FILL_REQ;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM state, window pointer, resident/spilled counts and error pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_bot   <= '0;
            r_oc    <= '0;
            r_sp    <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_err   <= w_err;
            if (w_save_fire) begin
                r_oc <= r_oc + OC_W'(1);
            end else if (w_restore_fire) begin
                r_oc <= r_oc - OC_W'(1);
            end else if (w_spill_done) begin
                r_bot <= r_bot + BANK_W'(1);
                r_oc  <= r_oc - OC_W'(1);
                r_sp  <= r_sp + DEPTH_W'(1);
            end else if (w_fill_done) begin
                r_bot <= r_bot - BANK_W'(1);
                r_oc  <= r_oc + OC_W'(1);
                r_sp  <= r_sp - DEPTH_W'(1);
            end
        end
    end

    // Frame slot storage: whole-frame writes on save, word writes on fill.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: this storage is reset on purpose so a stale frame can never
        // leak out after reset; plain RAM contents would normally be left
        // unreset.
        if (rst_i) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_slots[b] <= '0;
            end
        end else if (w_save_fire) begin
            r_slots[w_push_slot] <= save_data_i;
        end else if (w_fill_step) begin
            r_slots[w_fill_slot][w_word_idx] <= mem_rdata_i;
        end
    end

    shadow_bank_mem_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_mem_port (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .state_i        (r_state),
        .start_i        (w_start_spill || w_start_fill),
        .frame_base_i   (w_frame_base),
        .spill_word_i   (r_slots[r_bot][w_word_idx]),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .word_idx_o     (w_word_idx),
        .word_last_o    (w_word_last),
        .spill_step_o   (w_spill_step),
        .fill_granted_o (w_fill_granted),
        .fill_step_o    (w_fill_step)
    );

    // Status and top-of-stack views; all read as zero while reset is held.
    assign save_ready_o    = w_save_ok && !rst_i;
    assign restore_ready_o = w_restore_ok;
    assign restore_data_o  = (r_oc == '0) ? '0 : r_slots[w_top_slot];
    assign rd_data_o       = (r_oc == '0) ? '0 : r_slots[w_top_slot][rd_addr_i];
    assign depth_o         = w_depth;
    assign onchip_o        = r_oc;
    assign busy_o          = (r_state != S_IDLE);
    assign err_o           = r_err;

endmodule

// File: tb/tb_shadow_bank_stack.sv
// Directed bench for shadow_bank_stack with 2 slots, 4x32-bit frames, depth 4
// and a spill area at 0x1000. The memory responder grants one cycle after a
// request and returns read data one cycle after the grant.
module tb_shadow_bank_stack;

    localparam int DW = 32;
    localparam int NR = 4;
    localparam int NB = 2;
    localparam int MD = 4;
    localparam int FW = NR * DW;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          save_valid_i = 1'b0;
    logic          save_ready_o;
    logic [FW-1:0] save_data_i = '0;
    logic          restore_valid_i = 1'b0;
    logic          restore_ready_o;
    logic [FW-1:0] restore_data_o;
    logic [1:0]    rd_addr_i = '0;
    logic [DW-1:0] rd_data_o;
    logic [DW-1:0] stack_base_i = 32'h1000;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [DW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_gnt_i = 1'b0;
    logic          mem_rvalid_i = 1'b0;
    logic [DW-1:0] mem_rdata_i = '0;
    logic [2:0]    depth_o;
    logic [1:0]    onchip_o;
    logic          busy_o;
    logic          err_o;

    int n_checks = 0;
    int n_bad    = 0;

    logic [DW-1:0] mem_model [16];
    logic [DW-1:0] wr_addr_q [$];
    logic [DW-1:0] wr_data_q [$];
    logic [DW-1:0] rd_addr_q [$];

    shadow_bank_stack #(
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .NUM_BANKS  (NB),
        .MAX_DEPTH  (MD)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .save_valid_i    (save_valid_i),
        .save_ready_o    (save_ready_o),
        .save_data_i     (save_data_i),
        .restore_valid_i (restore_valid_i),
        .restore_ready_o (restore_ready_o),
        .restore_data_o  (restore_data_o),
        .rd_addr_i       (rd_addr_i),
        .rd_data_o       (rd_data_o),
        .stack_base_i    (stack_base_i),
        .mem_req_o       (mem_req_o),
        .mem_we_o        (mem_we_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_gnt_i       (mem_gnt_i),
        .mem_rvalid_i    (mem_rvalid_i),
        .mem_rdata_i     (mem_rdata_i),
        .depth_o         (depth_o),
        .onchip_o        (onchip_o),
        .busy_o          (busy_o),
        .err_o           (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk_frame(input logic [DW-1:0] tag);
        logic [FW-1:0] f;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = tag + DW'(i);
        return f;
    endfunction

    function automatic int midx(input logic [DW-1:0] a);
        logic [DW-1:0] off;
        off = (a - 32'h1000) >> 2;
        return int'(off[3:0]);
    endfunction

    // Memory responder: grant in the cycle after a request is first seen,
    // read data in the cycle after a read grant.
    initial begin
        logic          saw;
        logic          cap_we;
        logic [DW-1:0] cap_addr;
        logic [DW-1:0] cap_wdata;
        saw = 1'b0;
        cap_we = 1'b0;
        cap_addr = '0;
        cap_wdata = '0;
        for (int i = 0; i < 16; i++) mem_model[i] = '0;
        forever begin
            @(posedge clk_i);
            #1;
            if (rst_i) begin
                mem_gnt_i = 1'b0;
                mem_rvalid_i = 1'b0;
                saw = 1'b0;
            end else begin
                mem_rvalid_i = 1'b0;
                if (mem_gnt_i) begin
                    mem_gnt_i = 1'b0;
                    if (cap_we) begin
                        mem_model[midx(cap_addr)] = cap_wdata;
                        wr_addr_q.push_back(cap_addr);
                        wr_data_q.push_back(cap_wdata);
                    end else begin
                        mem_rvalid_i = 1'b1;
                        mem_rdata_i = mem_model[midx(cap_addr)];
                        rd_addr_q.push_back(cap_addr);
                    end
                end else if (saw && mem_req_o) begin
                    mem_gnt_i = 1'b1;
                    cap_we = mem_we_o;
                    cap_addr = mem_addr_o;
                    cap_wdata = mem_wdata_o;
                end
                saw = mem_req_o && !mem_gnt_i;
            end
        end
    end

    task automatic apply_reset();
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        save_valid_i = 1'b0;
        restore_valid_i = 1'b0;
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_addr_q.delete();
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    // Present a frame until accepted; stall counts cycles with ready low.
    task automatic push(input string tag, input logic [FW-1:0] f, output int stall);
        logic got;
        got = 1'b0;
        stall = 0;
        @(posedge clk_i);
        #1;
        save_data_i = f;
        save_valid_i = 1'b1;
        while (!got && stall < 100) begin
            @(negedge clk_i);
            if (save_ready_o) got = 1'b1;
            else stall++;
        end
        check({tag, "_accepted"}, got, 1'b1);
        @(posedge clk_i);
        #1;
        save_valid_i = 1'b0;
    endtask

    // Request a frame until returned; stall counts cycles with ready low.
    task automatic pop(input string tag, output logic [FW-1:0] f, output int stall);
        logic got;
        got = 1'b0;
        stall = 0;
        f = '0;
        @(posedge clk_i);
        #1;
        restore_valid_i = 1'b1;
        while (!got && stall < 100) begin
            @(negedge clk_i);
            if (restore_ready_o) begin
                got = 1'b1;
                f = restore_data_o;
            end else begin
                stall++;
            end
        end
        check({tag, "_returned"}, got, 1'b1);
        @(posedge clk_i);
        #1;
        restore_valid_i = 1'b0;
    endtask

    initial begin
        logic [FW-1:0] fa, fb, fc, fd, fe, got;
        int stall;
        int n;
        fa = mk_frame(32'hAAAA_0000);
        fb = mk_frame(32'hBBBB_0000);
        fc = mk_frame(32'hCCCC_0000);
        fd = mk_frame(32'hDDDD_0000);
        fe = mk_frame(32'hEEEE_0000);

        // Outputs while reset is held.
        #2 rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check("rst_save_ready", save_ready_o, 1'b0);
        check("rst_restore_ready", restore_ready_o, 1'b0);
        check("rst_mem_req", mem_req_o, 1'b0);
        check("rst_mem_addr", mem_addr_o, '0);
        check("rst_depth", depth_o, '0);
        check("rst_onchip", onchip_o, '0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_rd_data", rd_data_o, '0);
        check("rst_restore_data", restore_data_o, '0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("idle_save_ready", save_ready_o, 1'b1);

        // Two resident saves and a zero-stall restore.
        push("s1_a", fa, stall);
        check("s1_a_stall", stall, 0);
        push("s1_b", fb, stall);
        check("s1_b_stall", stall, 0);
        rd_addr_i = 2'd1;
        @(negedge clk_i);
        check("s1_depth2", depth_o, 3'd2);
        check("s1_rd_b1", rd_data_o, 32'hBBBB_0001);
        pop("s1_pop", got, stall);
        check("s1_pop_b", got, fb);
        check("s1_pop_stall", stall, 0);
        @(negedge clk_i);
        check("s1_depth1", depth_o, 3'd1);

        // Third save spills frame A to 0x1000..0x100C.
        apply_reset();
        push("s2_a", fa, stall);
        push("s2_b", fb, stall);
        push("s2_c", fc, stall);
        check("s2_c_stall", stall, 9);
        check("s2_nwrites", wr_addr_q.size(), 4);
        for (int i = 0; i < NR; i++) begin
            check($sformatf("s2_waddr%0d", i), wr_addr_q[i], 32'h1000 + 32'(4 * i));
            check($sformatf("s2_wdata%0d", i), wr_data_q[i], fa[i*DW +: DW]);
        end
        @(negedge clk_i);
        check("s2_onchip", onchip_o, 2'd2);
        check("s2_depth", depth_o, 3'd3);

        // Drain: C and B resident, then A filled back from memory.
        pop("s3_c", got, stall);
        check("s3_c_data", got, fc);
        pop("s3_b", got, stall);
        check("s3_b_data", got, fb);
        pop("s3_a", got, stall);
        check("s3_a_data", got, fa);
        check("s3_a_stall", stall, 13);
        check("s3_nreads", rd_addr_q.size(), 4);
        for (int i = 0; i < NR; i++) begin
            check($sformatf("s3_raddr%0d", i), rd_addr_q[i], 32'h1000 + 32'(4 * i));
        end
        @(negedge clk_i);
        check("s3_depth0", depth_o, 3'd0);
        check("s3_busy", busy_o, 1'b0);

        // Overflow at depth 4 and underflow at depth 0.
        apply_reset();
        push("s4_a", fa, stall);
        push("s4_b", fb, stall);
        push("s4_c", fc, stall);
        push("s4_d", fd, stall);
        @(posedge clk_i);
        #1;
        save_data_i = fe;
        save_valid_i = 1'b1;
        @(negedge clk_i);
        check("s4_ovf_ready", save_ready_o, 1'b0);
        check("s4_full_depth", depth_o, 3'd4);
        @(posedge clk_i);
        #1 save_valid_i = 1'b0;
        @(negedge clk_i);
        check("s4_ovf_err", err_o, 1'b1);
        check("s4_ovf_depth", depth_o, 3'd4);
        check("s4_ovf_onchip", onchip_o, 2'd2);
        check("s4_ovf_busy", busy_o, 1'b0);
        @(negedge clk_i);
        check("s4_ovf_pulse_end", err_o, 1'b0);
        pop("s4_pd", got, stall);
        check("s4_d_data", got, fd);
        pop("s4_pc", got, stall);
        check("s4_c_data", got, fc);
        pop("s4_pb", got, stall);
        check("s4_b_data", got, fb);
        check("s4_b_raddr0", rd_addr_q[0], 32'h1010);
        pop("s4_pa", got, stall);
        check("s4_a_data", got, fa);
        check("s4_a_raddr0", rd_addr_q[4], 32'h1000);
        @(posedge clk_i);
        #1 restore_valid_i = 1'b1;
        @(negedge clk_i);
        check("s4_unf_ready", restore_ready_o, 1'b0);
        @(posedge clk_i);
        #1 restore_valid_i = 1'b0;
        @(negedge clk_i);
        check("s4_unf_err", err_o, 1'b1);
        check("s4_unf_depth", depth_o, 3'd0);
        check("s4_unf_busy", busy_o, 1'b0);
        @(negedge clk_i);
        check("s4_unf_pulse_end", err_o, 1'b0);

        // Same-cycle save and restore with one resident frame.
        apply_reset();
        push("s5_a", fa, stall);
        @(posedge clk_i);
        #1;
        save_data_i = fb;
        save_valid_i = 1'b1;
        restore_valid_i = 1'b1;
        rd_addr_i = 2'd2;
        @(negedge clk_i);
        check("s5_restore_ready", restore_ready_o, 1'b1);
        check("s5_save_blocked", save_ready_o, 1'b0);
        check("s5_restore_data", restore_data_o, fa);
        @(posedge clk_i);
        #1 restore_valid_i = 1'b0;
        @(negedge clk_i);
        check("s5_depth_after_pop", depth_o, 3'd0);
        check("s5_save_ready", save_ready_o, 1'b1);
        @(posedge clk_i);
        #1 save_valid_i = 1'b0;
        @(negedge clk_i);
        check("s5_depth_after_push", depth_o, 3'd1);
        check("s5_rd_b2", rd_data_o, 32'hBBBB_0002);

        // Reset in the middle of the third spill write.
        apply_reset();
        push("s6_a", fa, stall);
        push("s6_b", fb, stall);
        @(posedge clk_i);
        #1;
        save_data_i = fc;
        save_valid_i = 1'b1;
        n = 0;
        while (wr_addr_q.size() < 2 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        check("s6_two_writes_seen", wr_addr_q.size(), 2);
        check("s6_third_req", mem_req_o, 1'b1);
        check("s6_third_addr", mem_addr_o, 32'h1008);
        #1;
        rst_i = 1'b1;
        save_valid_i = 1'b0;
        #1;
        check("s6_rst_req_drop", mem_req_o, 1'b0);
        check("s6_rst_depth", depth_o, 3'd0);
        check("s6_rst_busy", busy_o, 1'b0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        push("s6_d", fd, stall);
        check("s6_d_stall", stall, 0);
        @(negedge clk_i);
        check("s6_d_depth", depth_o, 3'd1);
        check("s6_d_busy", busy_o, 1'b0);
        check("s6_no_more_writes", wr_addr_q.size(), 2);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
